mul_sequencer: RTL and testbench
================================

Name: mul_sequencer

Overview:
- Multi-cycle MUL/MLA sequencer for the EXE stage. Reuses the shared 32-bit ALU through its ADD command via shift-add and produces the low 32 bits of the product, optionally plus an accumulator.
- While it owns the ALU, an external mux selects this block's val_1/val_2/exec_cmd/cin over the decoded instruction's. The hazard unit stalls the pipeline on busy.

Parameters:
- ADD_CMD, 4'b0010, exec_cmd encoding of ALU ADD.
- WIDTH, 32, operand/result width (fixed 32 in this design; parameter for bench only).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- accumulate  in  1  1 = MLA (product + acc_in), 0 = MUL.
- s_bit  in  1  update flags on completion.
- op_a  in  32  multiplicand (Rm).
- op_b  in  32  multiplier (Rs).
- acc_in  in  32  accumulator (Rn), used when accumulate=1.
- alu_res  in  32  result from shared ALU.
- alu_own  out  1  1 = ALU inputs come from this block.
- alu_val_1  out  32  to ALU val_1.
- alu_val_2  out  32  to ALU val_2.
- alu_exec_cmd  out  4  to ALU exec_cmd.
- alu_cin  out  1  to ALU cin.
- busy  out  1  request accepted and not yet done.
- done  out  1  one-cycle completion pulse.
- result  out  32  product, held until next accepted start.
- flag_n  out  1  result[31], valid with done.
- flag_z  out  1  result==0, valid with done.
- flag_we  out  1  done & latched s_bit; C and V are never written.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. busy, done, alu_own, flag_we = 0. result, internal regs and alu_val_1/alu_val_2 = 0. alu_exec_cmd=ADD_CMD, alu_cin=0.
- A reset mid-operation aborts with no done pulse.
- States: IDLE, ITER, DONE.
- IDLE:
  - alu_own=0, busy=0.
  - On start=1 latch: mcand=op_a, mplier=op_b, prod=(accumulate ? acc_in : 0), s_bit.
  - If op_b==0, go to DONE; else go to ITER.
- ITER, one ALU pass per cycle:
  - alu_own=1, busy=1, alu_exec_cmd=ADD_CMD, alu_cin=0.
  - alu_val_1=prod; alu_val_2=(mplier[0] ? mcand : 0). All combinational from registers.
  - At clock edge: prod<=alu_res; mcand<=mcand<<1 (bit 31 discarded); mplier<=mplier>>1.
  - Exit to DONE when the shifted mplier (next value) is 0. Iteration count = index of highest set bit of op_b + 1, at most 32.
- DONE:
  - busy=0, alu_own=0.
  - done=1 for exactly one cycle. result<=prod registered so it is visible in this cycle.
  - flag_n/flag_z from result; flag_we=s_bit latched.
  - Next state is always IDLE.
- start in DONE or ITER is ignored, not queued.
- Latency: start at edge k → done high in cycle k+1+N, where N = iteration count. op_b==0 gives done at cycle k+1.
- Arithmetic:
  - Modulo 2^32; the ALU carry-out and overflow are ignored.
  - Signed and unsigned low-32 products are identical, so there is no sign handling.
- busy is high from the cycle after an accepted start through the last ITER cycle.
- alu_own==busy at all times.
- result and flags hold their values after DONE until the next accepted start completes.

Test Plan:
- MUL op_a=3, op_b=5, s_bit=1 → 3 ITER cycles; alu_val_2 sequence 3,0,12; done at start+4; result=15, flag_n=0, flag_z=0, flag_we=1.
- MLA op_a=0xFFFFFFFF, op_b=2, acc_in=1, s_bit=1 → 2 ITER cycles; result=0xFFFFFFFF, flag_n=1, flag_z=0.
- MUL op_b=0, op_a=0x1234, s_bit=0 → no ITER; alu_own never 1; done one cycle after start; result=0, flag_z=1, flag_we=0.
- MUL op_a=0x80000000, op_b=0x80000000 → 32 ITER cycles (busy high for 32 cycles); result=0, flag_z=1.
- start pulsed again during ITER with different operands → ignored; result equals the first product. A new start the cycle after done is accepted.
- rst low for one cycle during ITER → busy, done, alu_own drop at once (asynchronous); state IDLE; no done pulse. A following MUL 7×6 returns 42.

Source files
------------

// File: rtl/mul_sequencer_if.sv
// mul_sequencer_if: request/result and shared-ALU signals of the MUL/MLA sequencer.
// Latency: none, wiring only.
// Backpressure: none; the requester observes busy/done, the ALU mux observes alu_own.
interface mul_sequencer_if #(
  parameter int WIDTH = 32
);
  // request side
  logic             start;
  logic             accumulate;
  logic             s_bit;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc_in;
  // shared ALU side
  logic [WIDTH-1:0] alu_res;
  logic             alu_own;
  logic [WIDTH-1:0] alu_val_1;
  logic [WIDTH-1:0] alu_val_2;
  logic [3:0]       alu_exec_cmd;
  logic             alu_cin;
  // status and result
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag_n;
  logic             flag_z;
  logic             flag_we;

  // environment: issues requests and closes the ALU loop
  modport master (
    output start, accumulate, s_bit, op_a, op_b, acc_in, alu_res,
    input  alu_own, alu_val_1, alu_val_2, alu_exec_cmd, alu_cin,
    input  busy, done, result, flag_n, flag_z, flag_we
  );

  // sequencer
  modport slave (
    input  start, accumulate, s_bit, op_a, op_b, acc_in, alu_res,
    output alu_own, alu_val_1, alu_val_2, alu_exec_cmd, alu_cin,
    output busy, done, result, flag_n, flag_z, flag_we
  );
endinterface

// File: rtl/mul_sequencer.sv
// mul_sequencer: shift-add MUL/MLA using the shared ALU ADD path; low 32 bits of a*b (+acc).
// Latency: done pulses N+1 cycles after an accepted start, N = index of op_b's top set bit + 1 (0 if op_b==0).
// Backpressure: none; start is sampled only in IDLE and dropped otherwise, busy stalls the pipeline.
module mul_sequencer #(
  parameter logic [3:0] ADD_CMD = 4'b0010,
  parameter int         WIDTH   = 32
) (
  input logic            clk,
  input logic            rst,
  mul_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] mplier_next;
  logic [WIDTH-1:0] seed;
  logic             s_held;
  logic             busy_r;
  logic             done_r;
  logic             flag_we_r;
  logic             flag_n_r;
  logic             flag_z_r;
  logic [WIDTH-1:0] result_r;

  // Multiplier after this pass; zero means the current pass is the last one.
  assign mplier_next = mplier >> 1;
  // Starting partial product: the accumulator for MLA, zero for MUL.
  assign seed        = bus.accumulate ? bus.acc_in : '0;

  // ALU operands come straight from the partial-product registers.
  assign bus.alu_val_1    = prod;
  assign bus.alu_val_2    = mplier[0] ? mcand : '0;
  assign bus.alu_exec_cmd = ADD_CMD;
  assign bus.alu_cin      = 1'b0;

  // One register backs both busy and alu_own so they can never disagree.
  assign bus.alu_own = busy_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.result  = result_r;
  assign bus.flag_n  = flag_n_r;
  assign bus.flag_z  = flag_z_r;
  assign bus.flag_we = flag_we_r;

  // Sequencer FSM: accept in IDLE, one ALU add per ITER cycle, one-cycle DONE with result/flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      prod      <= '0;
      s_held    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      flag_we_r <= 1'b0;
      flag_n_r  <= 1'b0;
      flag_z_r  <= 1'b0;
      result_r  <= '0;
    end else begin
      done_r    <= 1'b0;
      flag_we_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand  <= bus.op_a;
            mplier <= bus.op_b;
            prod   <= seed;
            s_held <= bus.s_bit;
            if (bus.op_b == '0) begin
              // Nothing to add: the product is the seed itself.
              state     <= DONE;
              done_r    <= 1'b1;
              flag_we_r <= bus.s_bit;
              result_r  <= seed;
              flag_n_r  <= seed[WIDTH-1];
              flag_z_r  <= (seed == '0);
            end else begin
              state  <= ITER;
              busy_r <= 1'b1;
            end
          end
        end
        ITER: begin
          prod   <= bus.alu_res;
          mcand  <= mcand << 1;
          mplier <= mplier_next;
          if (mplier_next == '0) begin
            // Last pass: publish the ALU sum directly so result is valid alongside done.
            state     <= DONE;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            flag_we_r <= s_held;
            result_r  <= bus.alu_res;
            flag_n_r  <= bus.alu_res[WIDTH-1];
            flag_z_r  <= (bus.alu_res == '0);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: scoreboard bench for mul_sequencer with a behavioural shared ALU.
// Latency: expected done cycle derived from op_b's highest set bit.
// Backpressure: none; the bench issues one request at a time.
module tb_mul_sequencer;
  localparam int         WIDTH   = 32;
  localparam logic [3:0] ADD_CMD = 4'b0010;

  typedef struct {
    logic [31:0] res;
    logic        n;
    logic        z;
    logic        we;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  logic [31:0] v2_log[$];
  int          own_cnt = 0;

  mul_sequencer_if #(.WIDTH(WIDTH)) bus();

  mul_sequencer #(.ADD_CMD(ADD_CMD), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Shared ALU: only ADD is meaningful here, anything else returns garbage.
  assign bus.alu_res = (bus.alu_exec_cmd == ADD_CMD) ?
                       (bus.alu_val_1 + bus.alu_val_2 + {31'b0, bus.alu_cin}) : 32'hDEAD_BEEF;

  // Monitor: log ALU usage, check ownership invariants, and pop the scoreboard on done.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.alu_own === 1'b1) begin
      v2_log.push_back(bus.alu_val_2);
      own_cnt++;
      checks++;
      if (bus.alu_exec_cmd !== ADD_CMD || bus.alu_cin !== 1'b0) begin
        failures++;
        $display("FAIL alu_cmd got cmd=%h cin=%b want cmd=%h cin=0", bus.alu_exec_cmd, bus.alu_cin, ADD_CMD);
      end
    end
    checks++;
    if (bus.alu_own !== bus.busy) begin
      failures++;
      $display("FAIL own_eq_busy got alu_own=%b busy=%b", bus.alu_own, bus.busy);
    end
    if (bus.done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done got done=1 result=%h want no done", bus.result);
      end else begin
        e = exp_q.pop_front();
        if (bus.result !== e.res || bus.flag_n !== e.n || bus.flag_z !== e.z || bus.flag_we !== e.we) begin
          failures++;
          $display("FAIL sb_result got res=%h n=%b z=%b we=%b want res=%h n=%b z=%b we=%b",
                   bus.result, bus.flag_n, bus.flag_z, bus.flag_we, e.res, e.n, e.z, e.we);
        end
      end
    end
  end

  function automatic int iters(input logic [31:0] b);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  // Drive a one-cycle start from the current negedge; optionally record the expected outcome.
  task automatic issue(input logic [31:0] a, b, acc, input logic accum, s, track);
    exp_t        e;
    logic [31:0] p;
    bus.op_a       = a;
    bus.op_b       = b;
    bus.acc_in     = acc;
    bus.accumulate = accum;
    bus.s_bit      = s;
    bus.start      = 1'b1;
    if (track) begin
      p    = a * b + (accum ? acc : 32'd0);
      e.res = p;
      e.n   = p[31];
      e.z   = (p == 32'd0);
      e.we  = s;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Extra negedges until done is seen; 100 on timeout so the caller's latency check fails.
  task automatic wait_done(output int k);
    k = 0;
    while (bus.done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.alu_own, bus.flag_we} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got busy/done/own/we=%b want 0000", {bus.busy, bus.done, bus.alu_own, bus.flag_we});
    end
    checks++;
    if (bus.result !== 32'd0 || bus.alu_val_1 !== 32'd0 || bus.alu_val_2 !== 32'd0) begin
      failures++;
      $display("FAIL reset_data got res=%h v1=%h v2=%h want 0", bus.result, bus.alu_val_1, bus.alu_val_2);
    end
    checks++;
    if (bus.alu_exec_cmd !== ADD_CMD || bus.alu_cin !== 1'b0) begin
      failures++;
      $display("FAIL reset_alu got cmd=%h cin=%b want cmd=%h cin=0", bus.alu_exec_cmd, bus.alu_cin, ADD_CMD);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul_basic();
    int k;
    v2_log.delete();
    own_cnt = 0;
    issue(32'd3, 32'd5, 32'd0, 1'b0, 1'b1, 1'b1);
    wait_done(k);
    checks++;
    if (k + 1 !== iters(32'd5) + 1) begin
      failures++;
      $display("FAIL mul_latency got %0d want %0d", k + 1, iters(32'd5) + 1);
    end
    checks++;
    if (own_cnt !== 3) begin
      failures++;
      $display("FAIL mul_own_cycles got %0d want 3", own_cnt);
    end
    checks++;
    if (v2_log.size() !== 3 || v2_log[0] !== 32'd3 || v2_log[1] !== 32'd0 || v2_log[2] !== 32'd12) begin
      failures++;
      $display("FAIL mul_val2_seq got size=%0d want 3,0,12", v2_log.size());
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.flag_we !== 1'b0 || bus.result !== 32'd15) begin
      failures++;
      $display("FAIL mul_hold got done=%b we=%b res=%h want 0 0 0000000f", bus.done, bus.flag_we, bus.result);
    end
  endtask

  task automatic test_mla_wrap();
    int k;
    own_cnt = 0;
    issue(32'hFFFF_FFFF, 32'd2, 32'd1, 1'b1, 1'b1, 1'b1);
    wait_done(k);
    checks++;
    if (k + 1 !== 3 || own_cnt !== 2) begin
      failures++;
      $display("FAIL mla_latency got lat=%0d own=%0d want lat=3 own=2", k + 1, own_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_mult();
    int k;
    own_cnt = 0;
    issue(32'h1234, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    wait_done(k);
    checks++;
    if (k + 1 !== 1) begin
      failures++;
      $display("FAIL zero_latency got %0d want 1", k + 1);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (own_cnt !== 0) begin
      failures++;
      $display("FAIL zero_own got %0d cycles want 0", own_cnt);
    end
  endtask

  task automatic test_full_width();
    int k;
    own_cnt = 0;
    issue(32'h8000_0000, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1'b1);
    wait_done(k);
    checks++;
    if (k + 1 !== 33 || own_cnt !== 32) begin
      failures++;
      $display("FAIL full_latency got lat=%0d own=%0d want lat=33 own=32", k + 1, own_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int k;
    issue(32'd7, 32'd15, 32'd0, 1'b0, 1'b1, 1'b1);
    // second request lands in ITER and must be dropped
    bus.op_a  = 32'd9;
    bus.op_b  = 32'd9;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(k);
    checks++;
    if (k + 2 !== iters(32'd15) + 1) begin
      failures++;
      $display("FAIL ignore_latency got %0d want %0d", k + 2, iters(32'd15) + 1);
    end
    @(negedge clk);
    issue(32'd11, 32'd3, 32'd5, 1'b1, 1'b0, 1'b1);
    wait_done(k);
    checks++;
    if (k + 1 !== iters(32'd3) + 1) begin
      failures++;
      $display("FAIL b2b_latency got %0d want %0d", k + 1, iters(32'd3) + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int k;
    issue(32'h0000_ABCD, 32'h0000_FF00, 32'd0, 1'b0, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.alu_own !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL abort_async got busy=%b own=%b done=%b want 000", bus.busy, bus.alu_own, bus.done);
    end
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    issue(32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 1'b1);
    wait_done(k);
    checks++;
    if (k + 1 !== 4) begin
      failures++;
      $display("FAIL abort_next_latency got %0d want 4", k + 1);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.accumulate = 1'b0;
    bus.s_bit      = 1'b0;
    bus.op_a       = '0;
    bus.op_b       = '0;
    bus.acc_in     = '0;
    test_reset();
    test_mul_basic();
    test_mla_wrap();
    test_zero_mult();
    test_full_width();
    test_back_to_back();
    test_reset_abort();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL sb_drain got %0d pending want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1);
  end

endmodule
